// File: rtl/axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_packet_arbiter
//
// Shares one AXI-Stream master port between NUM_SRC AXI-Stream slave ports.
// Arbitration is round-robin and packet-atomic: once a source is granted it
// owns the output until its s_last beat has been accepted. The master side is
// a registered pipeline stage, so there is no combinational path from s_* to
// m_*. One idle arbitration cycle separates consecutive packets.
//
// Optional feature macro: AXIS_ARB_ID_EN
//   defined   -> m_id port and id register present (grant index of each beat)
//   undefined -> no m_id port, no id register
//
// Ports
//   clk      in   1                          rising-edge clock
//   rstn     in   1                          asynchronous active-low reset
//   s_valid  in   [NUM_SRC]                  per-source valid
//   s_ready  out  [NUM_SRC]                  per-source ready
//   s_data   in   [NUM_SRC][WPB][WORD_W]     per-source data
//   s_keep   in   [NUM_SRC][WPB]             per-source word keep
//   s_last   in   [NUM_SRC]                  per-source end of packet
//   m_valid  out  1                          output valid (registered)
//   m_ready  in   1                          output ready
//   m_data   out  [WPB][WORD_W]              output data (registered)
//   m_keep   out  [WPB]                      output keep (registered)
//   m_last   out  1                          output last (registered)
//   m_id     out  SRC_W                      source index of m beat (AXIS_ARB_ID_EN)
// -----------------------------------------------------------------------------
module axis_packet_arbiter #(
  parameter  int WORD_W  = 8,
  parameter  int BUS_W   = 32,
  parameter  int NUM_SRC = 4,
  localparam int WPB     = BUS_W / WORD_W,
  localparam int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                     clk,
  input  logic                                     rstn,
  input  logic [NUM_SRC-1:0]                       s_valid,
  output logic [NUM_SRC-1:0]                       s_ready,
  input  logic [NUM_SRC-1:0][WPB-1:0][WORD_W-1:0]  s_data,
  input  logic [NUM_SRC-1:0][WPB-1:0]              s_keep,
  input  logic [NUM_SRC-1:0]                       s_last,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [WPB-1:0][WORD_W-1:0]               m_data,
  output logic [WPB-1:0]                           m_keep,
  output logic                                     m_last
`ifdef AXIS_ARB_ID_EN
  ,
  output logic [SRC_W-1:0]                         m_id
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [SRC_W-1:0]          grant_q, grant_d;
  logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;

  logic                      m_valid_q, m_valid_d;
  logic [WPB-1:0][WORD_W-1:0] m_data_q, m_data_d;
  logic [WPB-1:0]            m_keep_q, m_keep_d;
  logic                      m_last_q, m_last_d;
`ifdef AXIS_ARB_ID_EN
  logic [SRC_W-1:0]          m_id_q, m_id_d;
`endif

  logic                      arb_found_s;
  logic [SRC_W-1:0]          arb_idx_s;
  logic                      out_free_s;
  logic                      beat_hs_s;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free_s = ~m_valid_q | m_ready;

  // Round-robin scan: first requester at rr_ptr+1, rr_ptr+2, ... mod NUM_SRC.
  always_comb begin : arb_scan
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    logic             hit;
    arb_found_s = 1'b0;
    arb_idx_s   = '0;
    cand        = 0;
    cand_idx    = '0;
    hit         = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand        = int'(rr_ptr_q) + 1 + i;
      // rr_ptr_q <= NUM_SRC-1, so one wrap is always enough.
      cand        = (cand >= NUM_SRC) ? (cand - NUM_SRC) : cand;
      cand_idx    = SRC_W'(cand);
      hit         = ~arb_found_s & s_valid[cand_idx];
      arb_idx_s   = hit ? cand_idx : arb_idx_s;
      arb_found_s = arb_found_s | hit;
    end
  end

  // FSM next state, grant/rr pointer update and per-source ready.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    s_ready   = '0;
    beat_hs_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found_s) begin
          grant_d = arb_idx_s;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        s_ready[grant_q] = out_free_s;
        beat_hs_s        = s_valid[grant_q] & out_free_s;
        // The packet releases the grant only when its last beat is taken;
        // a source that pauses mid-packet keeps ownership indefinitely.
        if (beat_hs_s && s_last[grant_q]) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output pipeline register next state: load on handshake, clear on drain.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
`ifdef AXIS_ARB_ID_EN
    m_id_d    = m_id_q;
`endif
    if (beat_hs_s) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data[grant_q];
      m_keep_d  = s_keep[grant_q];
      m_last_d  = s_last[grant_q];
`ifdef AXIS_ARB_ID_EN
      m_id_d    = grant_q;
`endif
    end else if (m_ready) begin
      // Payload is left as-is; only valid drops once the beat is consumed.
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // FSM state, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= SRC_W'(NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output stage registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
`ifdef AXIS_ARB_ID_EN
      m_id_q    <= '0;
`endif
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
`ifdef AXIS_ARB_ID_EN
      m_id_q    <= m_id_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
`ifdef AXIS_ARB_ID_EN
  assign m_id    = m_id_q;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for axis_packet_arbiter (WORD_W=8, BUS_W=32, NUM_SRC=4).
// Table-driven cycle vectors for the single-source and two-source packet
// cases, plus hand-written sequences for round-robin fairness, random
// backpressure and mid-packet reset. Beat payload for source s with tag d is
// {s, d, ~d, d} with keep ~d[3:0], so every beat identifies its origin.
// -----------------------------------------------------------------------------
module tb_axis_packet_arbiter;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [3:0]            s_valid;
  logic [3:0]            s_ready;
  logic [3:0][3:0][7:0]  s_data;
  logic [3:0][3:0]       s_keep;
  logic [3:0]            s_last;
  logic                  m_valid;
  logic                  m_ready;
  logic [3:0][7:0]       m_data;
  logic [3:0]            m_keep;
  logic                  m_last;
`ifdef AXIS_ARB_ID_EN
  logic [1:0]            m_id;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_packet_arbiter #(.WORD_W(8), .BUS_W(32), .NUM_SRC(4)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last)
`ifdef AXIS_ARB_ID_EN
    ,
    .m_id    (m_id)
`endif
  );

  typedef struct {
    logic [3:0]      sv;
    logic [3:0]      sl;
    logic [3:0][7:0] d;
    logic            mr;
    logic            emv;
    logic            eml;
    logic [1:0]      esrc;
    logic [7:0]      ed;
    logic [3:0]      esr;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mkd(int s, logic [7:0] d);
    return {8'(s), d, ~d, d};
  endfunction

  function automatic logic [3:0] mkk(logic [7:0] d);
    return ~d[3:0];
  endfunction

  function automatic vec_t row(logic [3:0] sv, logic [3:0] sl, logic [31:0] d,
                               logic mr, logic emv, logic eml, logic [1:0] esrc,
                               logic [7:0] ed, logic [3:0] esr);
    vec_t v;
    v.sv = sv; v.sl = sl; v.d = d; v.mr = mr; v.emv = emv; v.eml = eml;
    v.esrc = esrc; v.ed = ed; v.esr = esr;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_src(int s, logic [7:0] d);
    s_data[s] = mkd(s, d);
    s_keep[s] = mkk(d);
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, " m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, " m_data"},  64'(m_data),  64'd0);
    chk({tag, " m_keep"},  64'(m_keep),  64'd0);
    chk({tag, " m_last"},  64'(m_last),  64'd0);
    chk({tag, " s_ready"}, 64'(s_ready), 64'd0);
`ifdef AXIS_ARB_ID_EN
    chk({tag, " m_id"},    64'(m_id),    64'd0);
`endif
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_cleared(tag);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_table(string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      s_valid = tbl[i].sv;
      s_last  = tbl[i].sl;
      m_ready = tbl[i].mr;
      for (int s = 0; s < 4; s++) drive_src(s, tbl[i].d[s]);
      #1;
      chk($sformatf("%s[%0d] s_ready", tag, i), 64'(s_ready), 64'(tbl[i].esr));
      chk($sformatf("%s[%0d] m_valid", tag, i), 64'(m_valid), 64'(tbl[i].emv));
      if (tbl[i].emv) begin
        chk($sformatf("%s[%0d] m_data", tag, i), 64'(m_data),
            64'(mkd(int'(tbl[i].esrc), tbl[i].ed)));
        chk($sformatf("%s[%0d] m_keep", tag, i), 64'(m_keep), 64'(mkk(tbl[i].ed)));
        chk($sformatf("%s[%0d] m_last", tag, i), 64'(m_last), 64'(tbl[i].eml));
`ifdef AXIS_ARB_ID_EN
        chk($sformatf("%s[%0d] m_id", tag, i), 64'(m_id), 64'(tbl[i].esrc));
`endif
      end
    end
    tbl.delete();
  endtask

  initial begin
    logic [31:0] q3[$];
    logic [63:0] q4[$];
    int          cnt[4];
    int          ngrant;
    int          b;
    int          nrx;
    logic        prev_stall;
    logic [63:0] prev_m;
    logic [63:0] cur;

    rstn    = 1'b0;
    s_valid = 4'hF;
    s_last  = 4'h0;
    s_data  = '0;
    s_keep  = '0;
    m_ready = 1'b0;
    #12;
    chk_cleared("reset");
    @(negedge clk);
    rstn    = 1'b1;
    s_valid = 4'h0;

    // Test 1: source 1 alone, 5-beat packet, m_ready high.
    tbl.push_back(row(4'b0010, 4'b0000, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000));
    tbl.push_back(row(4'b0010, 4'b0000, 32'h0000_0100, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0010));
    tbl.push_back(row(4'b0010, 4'b0000, 32'h0000_0200, 1'b1, 1'b1, 1'b0, 2'd1, 8'd1, 4'b0010));
    tbl.push_back(row(4'b0010, 4'b0000, 32'h0000_0300, 1'b1, 1'b1, 1'b0, 2'd1, 8'd2, 4'b0010));
    tbl.push_back(row(4'b0010, 4'b0000, 32'h0000_0400, 1'b1, 1'b1, 1'b0, 2'd1, 8'd3, 4'b0010));
    tbl.push_back(row(4'b0010, 4'b0010, 32'h0000_0500, 1'b1, 1'b1, 1'b0, 2'd1, 8'd4, 4'b0010));
    tbl.push_back(row(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 2'd1, 8'd5, 4'b0000));
    tbl.push_back(row(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000));
    run_table("t1");

    // Test 2 (and id check when enabled): sources 0 and 2 request together.
    do_reset("t2 reset");
    tbl.push_back(row(4'b0101, 4'b0000, 32'h0001_0001, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000));
    tbl.push_back(row(4'b0101, 4'b0000, 32'h0001_0001, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0001));
    tbl.push_back(row(4'b0101, 4'b0000, 32'h0001_0002, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1, 4'b0001));
    tbl.push_back(row(4'b0101, 4'b0001, 32'h0001_0003, 1'b1, 1'b1, 1'b0, 2'd0, 8'd2, 4'b0001));
    tbl.push_back(row(4'b0100, 4'b0000, 32'h0001_0000, 1'b1, 1'b1, 1'b1, 2'd0, 8'd3, 4'b0000));
    tbl.push_back(row(4'b0100, 4'b0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0100));
    tbl.push_back(row(4'b0100, 4'b0000, 32'h0002_0000, 1'b1, 1'b1, 1'b0, 2'd2, 8'd1, 4'b0100));
    tbl.push_back(row(4'b0100, 4'b0100, 32'h0003_0000, 1'b0, 1'b1, 1'b0, 2'd2, 8'd2, 4'b0000));
    tbl.push_back(row(4'b0100, 4'b0100, 32'h0003_0000, 1'b1, 1'b1, 1'b0, 2'd2, 8'd2, 4'b0100));
    tbl.push_back(row(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 2'd2, 8'd3, 4'b0000));
    tbl.push_back(row(4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000));
    // rr_ptr is now 2: with everyone requesting, source 3 must win next.
    tbl.push_back(row(4'b1111, 4'b1111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b0000));
    tbl.push_back(row(4'b1111, 4'b1111, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 4'b1000));
    run_table("t2");

    // Test 3: all sources stream single-beat packets; expect 0,1,2,3,0,...
    do_reset("t3 reset");
    s_valid = 4'b1111;
    s_last  = 4'b1111;
    m_ready = 1'b1;
    for (int s = 0; s < 4; s++) cnt[s] = 0;
    ngrant = 0;
    for (int cyc = 0; cyc < 100 && ngrant < 12; cyc++) begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) drive_src(s, 8'(cnt[s]));
      #1;
      if (m_valid) begin
        if (q3.size() > 0) chk("t3 m_data", 64'(m_data), 64'(q3.pop_front()));
        else               chk("t3 unexpected beat", 64'(m_valid), 64'd0);
      end
      for (int s = 0; s < 4; s++) begin
        if (s_ready[s]) begin
          chk("t3 grant order", 64'(s), 64'(ngrant % 4));
          q3.push_back(mkd(s, 8'(cnt[s])));
          cnt[s]++;
          ngrant++;
        end
      end
    end
    chk("t3 grant count", 64'(ngrant), 64'd12);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      s_valid = 4'b0000;
      #1;
      if (m_valid) begin
        if (q3.size() > 0) chk("t3 drain m_data", 64'(m_data), 64'(q3.pop_front()));
        else               chk("t3 unexpected beat", 64'(m_valid), 64'd0);
      end
    end
    chk("t3 queue empty", 64'(q3.size()), 64'd0);
    for (int s = 0; s < 4; s++) chk($sformatf("t3 packets src%0d", s), 64'(cnt[s]), 64'd3);

    // Test 4: source 3, 8-beat packet, m_ready high about 10% of cycles.
    s_last     = 4'b0000;
    b          = 0;
    nrx        = 0;
    prev_stall = 1'b0;
    prev_m     = '0;
    for (int cyc = 0; cyc < 3000 && nrx < 8; cyc++) begin
      @(negedge clk);
      s_valid = {(b < 8), 3'b000};
      s_last  = {(b == 7), 3'b000};
      drive_src(3, 8'(b + 16));
      m_ready = ($urandom_range(0, 9) == 0);
      #1;
`ifdef AXIS_ARB_ID_EN
      cur = {25'd0, m_id, m_last, m_keep, m_data};
`else
      cur = {27'd0, m_last, m_keep, m_data};
`endif
      if (prev_stall) begin
        chk("t4 stall valid", 64'(m_valid), 64'd1);
        chk("t4 stall hold", cur, prev_m);
      end
      if (m_valid && m_ready) begin
        if (q4.size() > 0) chk("t4 beat", cur, q4.pop_front());
        else               chk("t4 unexpected beat", 64'(m_valid), 64'd0);
        nrx++;
      end
      if (s_valid[3] && s_ready[3]) begin
`ifdef AXIS_ARB_ID_EN
        q4.push_back({25'd0, 2'd3, (b == 7), mkk(8'(b + 16)), mkd(3, 8'(b + 16))});
`else
        q4.push_back({27'd0, (b == 7), mkk(8'(b + 16)), mkd(3, 8'(b + 16))});
`endif
        b++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_m     = cur;
    end
    chk("t4 beats received", 64'(nrx), 64'd8);
    chk("t4 queue empty", 64'(q4.size()), 64'd0);

    // Test 5: reset pulse while source 1 is mid-packet.
    @(negedge clk);
    s_valid = 4'b0000;
    s_last  = 4'b0000;
    m_ready = 1'b1;
    do_reset("t5 reset");
    s_valid = 4'b0010;
    b       = 0;
    for (int cyc = 0; cyc < 50 && b < 2; cyc++) begin
      @(negedge clk);
      drive_src(1, 8'(b + 40));
      #1;
      if (s_ready[1]) b++;
    end
    chk("t5 beats before reset", 64'(b), 64'd2);
    @(negedge clk);
    drive_src(1, 8'(b + 40));
    #1;
    chk("t5 m_valid before reset", 64'(m_valid), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk_cleared("t5 async");
    @(negedge clk);
    s_valid = 4'b0011;
    rstn    = 1'b1;
    #1;
    chk("t5 idle s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("t5 source 0 wins", 64'(s_ready), 64'b0001);

    @(negedge clk);
    s_valid = 4'b0000;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
